// File: rtl/tessent_scanmux_pkg.sv
// Shared types and helpers for the N-way secure IJTAG scan mux.
//   sel_update_e : outcome of a select-register update attempt
//   FAIL_CNT_W   : width of the consecutive wrong-key counter
//   onehot_dec   : index to one-hot decode (supports up to 32 inputs)
package tessent_scanmux_pkg;

  typedef enum logic [1:0] {
    UPD_OK,
    UPD_BADKEY,
    UPD_RANGE,
    UPD_LOCKED
  } sel_update_e;

  localparam int FAIL_CNT_W = 4;

  function automatic logic [31:0] onehot_dec(input logic [31:0] idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/tessent_scanmux_key_chk.sv
// Key comparison, consecutive wrong-key counter and lockout flag for the
// secure scan mux. Only instantiated when TESSENT_SCANMUX_KEY_EN is defined.
// Ports:
//   clk, reset    : IJTAG TCK and synchronous active-high reset
//   upd_req       : an update is being applied at this edge
//   key_field     : key bits of the shift register (pre-edge)
//   sel_in_range  : select field of the shift register is < NUM_IN
//   upd_status    : classification of the update attempt
//   locked        : lockout active; stays set until reset
module tessent_scanmux_key_chk
  import tessent_scanmux_pkg::*;
#(
  parameter int               KEY_W    = 8,
  parameter logic [KEY_W-1:0] KEY      = 8'hA5,
  parameter int               MAX_FAIL = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             upd_req,
  input  logic [KEY_W-1:0] key_field,
  input  logic             sel_in_range,
  output sel_update_e      upd_status,
  output logic             locked
);

  localparam logic [FAIL_CNT_W-1:0] MAX_FAIL_C = FAIL_CNT_W'(MAX_FAIL);

  logic [FAIL_CNT_W-1:0] fail_cnt;

  // Lockout outranks the key check, and a correct key outranks the range
  // check, so a wrong key never reveals whether the select was valid.
  always_comb begin
    upd_status = UPD_OK;
    if (locked)
      upd_status = UPD_LOCKED;
    else if (key_field != KEY)
      upd_status = UPD_BADKEY;
    else if (!sel_in_range)
      upd_status = UPD_RANGE;
  end

  // Any update carrying the right key clears the counter, even if the
  // select itself is rejected as out of range.
  always_ff @(posedge clk) begin
    if (reset) begin
      fail_cnt <= '0;
      locked   <= 1'b0;
    end else if (upd_req) begin
      unique case (upd_status)
        UPD_BADKEY: begin
          if (fail_cnt != MAX_FAIL_C)
            fail_cnt <= fail_cnt + FAIL_CNT_W'(1);
          if (fail_cnt + FAIL_CNT_W'(1) == MAX_FAIL_C)
            locked <= 1'b1;
        end
        UPD_RANGE, UPD_OK: fail_cnt <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tessent_scanmux_nway_secure_ctrl.sv
// N-way IJTAG scan-path multiplexer owning its shift/update select register.
// Optional keying: define TESSENT_SCANMUX_KEY_EN to add a key field to the
// shift register, the wrong-key counter and the lockout flag.
// Ports:
//   ijtag_tck, ijtag_reset          : clock and synchronous active-high reset
//   ijtag_sel/ce/se/ue, ijtag_si/so : IJTAG segment access
//   mux_in, mux_out                 : scan data inputs and selected output
//   enable_in, enable_out           : upstream enable, one-hot gated enables
//   range_err                       : sticky out-of-range select attempt
//   locked                          : key lockout (0 without keying)
module tessent_scanmux_nway_secure_ctrl
  import tessent_scanmux_pkg::*;
#(
  parameter int               NUM_IN      = 4,
  parameter int               SEL_W       = $clog2(NUM_IN),
  parameter int               DEFAULT_SEL = 0,
  parameter int               KEY_W       = 8,
  parameter logic [KEY_W-1:0] KEY         = 8'hA5,
  parameter int               MAX_FAIL    = 3
) (
  input  logic              ijtag_tck,
  input  logic              ijtag_reset,
  input  logic              ijtag_sel,
  input  logic              ijtag_ce,
  input  logic              ijtag_se,
  input  logic              ijtag_ue,
  input  logic              ijtag_si,
  output logic              ijtag_so,
  input  logic [NUM_IN-1:0] mux_in,
  output logic              mux_out,
  input  logic              enable_in,
  output logic [NUM_IN-1:0] enable_out,
  output logic              range_err,
  output logic              locked
);

`ifdef TESSENT_SCANMUX_KEY_EN
  localparam int SR_W = KEY_W + SEL_W;
`else
  localparam int SR_W = SEL_W;
`endif

  if (NUM_IN < 2 || NUM_IN > 32 || DEFAULT_SEL >= NUM_IN || KEY_W < 2 ||
      $bits(KEY) != KEY_W || MAX_FAIL < 1 || MAX_FAIL > 15) begin : g_param_chk
    $error("tessent_scanmux_nway_secure_ctrl: illegal parameter set");
  end

  logic [SR_W-1:0]  sr;
  logic [SR_W-1:0]  sr_cap;
  logic [SR_W-1:0]  sr_shift;
  logic [SEL_W-1:0] sel_q;
  logic [31:0]      dec_full;
  logic             upd_req;
  logic             sel_in_range;
  sel_update_e      upd_status;

  assign upd_req      = ijtag_sel & ijtag_ue;
  assign sel_in_range = (32'(sr[SEL_W-1:0]) < 32'(NUM_IN));
  assign ijtag_so     = sr[0];

`ifdef TESSENT_SCANMUX_KEY_EN
  tessent_scanmux_key_chk #(
    .KEY_W   (KEY_W),
    .KEY     (KEY),
    .MAX_FAIL(MAX_FAIL)
  ) u_key_chk (
    .clk         (ijtag_tck),
    .reset       (ijtag_reset),
    .upd_req     (upd_req),
    .key_field   (sr[SR_W-1:SEL_W]),
    .sel_in_range(sel_in_range),
    .upd_status  (upd_status),
    .locked      (locked)
  );
`else
  assign upd_status = sel_in_range ? UPD_OK : UPD_RANGE;
  assign locked     = 1'b0;
`endif

  // Capture image: current select in the low field; with keying, the status
  // bits sit at the top of the key field so the key itself is never exposed.
  // Shift image is built by bit assignment so a 1-bit register also works.
  always_comb begin
    sr_cap             = '0;
    sr_cap[SEL_W-1:0]  = sel_q;
`ifdef TESSENT_SCANMUX_KEY_EN
    sr_cap[SR_W-1]     = locked;
    sr_cap[SR_W-2]     = range_err;
`endif
    sr_shift           = sr >> 1;
    sr_shift[SR_W-1]   = ijtag_si;
  end

  // Shift register and select state. The update decision uses the pre-edge
  // register contents, so it is independent of a concurrent capture/shift.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      sr        <= '0;
      sel_q     <= SEL_W'(DEFAULT_SEL);
      range_err <= 1'b0;
    end else begin
      if (ijtag_sel & ijtag_ce)
        sr <= sr_cap;
      else if (ijtag_sel & ijtag_se)
        sr <= sr_shift;
      if (upd_req && upd_status == UPD_OK)
        sel_q <= sr[SEL_W-1:0];
      if (upd_req && upd_status == UPD_RANGE)
        range_err <= 1'b1;
    end
  end

  // sel_q is always in range, so the decode is strictly one-hot.
  always_comb begin
    dec_full   = onehot_dec(32'(sel_q));
    enable_out = dec_full[NUM_IN-1:0] & {NUM_IN{enable_in}};
    mux_out    = mux_in[sel_q];
  end

endmodule

// File: tb/tb_tessent_scanmux_nway_secure_ctrl.sv
// Bench for tessent_scanmux_nway_secure_ctrl. Two instances share every
// IJTAG input: one with NUM_IN=4 and one with NUM_IN=3, so the same select
// value 3 is legal on one and out of range on the other.
// Works with or without TESSENT_SCANMUX_KEY_EN defined.
module tb_tessent_scanmux_nway_secure_ctrl;

`ifdef TESSENT_SCANMUX_KEY_EN
  localparam bit KEY_ON  = 1'b1;
  localparam int SRW_TB  = 10;
`else
  localparam bit KEY_ON  = 1'b0;
  localparam int SRW_TB  = 2;
`endif
  localparam int MAXF = 3;

  logic       tck = 1'b0;
  logic       reset, sel, ce, se, ue, si, enable_in;
  logic [3:0] mux_in;
  logic       so4, so3, mux_out4, mux_out3, rerr4, rerr3, lock4, lock3;
  logic [3:0] en4;
  logic [2:0] en3;

  int  vectors = 0;
  int  miscompares = 0;
  bit  chk_en = 1'b0;

  // Reference state per instance: index 0 is NUM_IN=4, index 1 is NUM_IN=3.
  int  m_num[2] = '{4, 3};
  int  m_sel[2];
  int  m_fail[2];
  bit  m_locked[2];
  bit  m_range[2];

  always #5 tck = ~tck;

  tessent_scanmux_nway_secure_ctrl #(
    .NUM_IN(4), .DEFAULT_SEL(0), .KEY_W(8), .KEY(8'hA5), .MAX_FAIL(MAXF)
  ) dut (
    .ijtag_tck(tck), .ijtag_reset(reset), .ijtag_sel(sel), .ijtag_ce(ce),
    .ijtag_se(se), .ijtag_ue(ue), .ijtag_si(si), .ijtag_so(so4),
    .mux_in(mux_in), .mux_out(mux_out4), .enable_in(enable_in),
    .enable_out(en4), .range_err(rerr4), .locked(lock4)
  );

  tessent_scanmux_nway_secure_ctrl #(
    .NUM_IN(3), .DEFAULT_SEL(0), .KEY_W(8), .KEY(8'hA5), .MAX_FAIL(MAXF)
  ) dut3 (
    .ijtag_tck(tck), .ijtag_reset(reset), .ijtag_sel(sel), .ijtag_ce(ce),
    .ijtag_se(se), .ijtag_ue(ue), .ijtag_si(si), .ijtag_so(so3),
    .mux_in(mux_in[2:0]), .mux_out(mux_out3), .enable_in(enable_in),
    .enable_out(en3), .range_err(rerr3), .locked(lock3)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One clock: inputs change just after the edge, data inputs get new values.
  task automatic tick();
    @(posedge tck);
    #1;
    mux_in = 4'($urandom);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_sel[k] = 0; m_fail[k] = 0; m_locked[k] = 1'b0; m_range[k] = 1'b0;
    end
  endtask

  task automatic model_update(input logic [7:0] key, input int s);
    for (int k = 0; k < 2; k++) begin
      if (m_locked[k]) begin
      end else if (KEY_ON && key != 8'hA5) begin
        m_fail[k] = (m_fail[k] + 1 > MAXF) ? MAXF : m_fail[k] + 1;
        if (m_fail[k] == MAXF) m_locked[k] = 1'b1;
      end else if (s >= m_num[k]) begin
        m_range[k] = 1'b1;
        m_fail[k]  = 0;
      end else begin
        m_sel[k]  = s;
        m_fail[k] = 0;
      end
    end
  endtask

  function automatic int capture_word(input int k);
    if (KEY_ON) return (int'(m_locked[k]) << 9) | (int'(m_range[k]) << 8) | m_sel[k];
    return m_sel[k];
  endfunction

  // Shift a {key, select} word in LSB first, then optionally update.
  task automatic applyStimulus(input logic [7:0] key, input int s, input bit do_upd);
    logic [SRW_TB-1:0] word;
`ifdef TESSENT_SCANMUX_KEY_EN
    word = {key, 2'(s)};
`else
    word = 2'(s);
`endif
    sel = 1'b1; se = 1'b1;
    for (int i = 0; i < SRW_TB; i++) begin
      si = word[i];
      tick();
    end
    se = 1'b0; si = 1'b0;
    if (do_upd) begin
      ue = 1'b1;
      tick();
      ue = 1'b0;
      model_update(key, s);
    end
    sel = 1'b0;
  endtask

  // Capture, then read the whole register back through ijtag_so.
  task automatic capture_check(input string name);
    int got4, got3;
    got4 = 0; got3 = 0;
    sel = 1'b1; ce = 1'b1;
    tick();
    ce = 1'b0; se = 1'b1; si = 1'b0;
    for (int i = 0; i < SRW_TB; i++) begin
      got4 |= int'(so4) << i;
      got3 |= int'(so3) << i;
      tick();
    end
    se = 1'b0; sel = 1'b0;
    checkOutput({name, "_cap4"}, got4, capture_word(0));
    checkOutput({name, "_cap3"}, got3, capture_word(1));
  endtask

  // Every cycle: mux, enables and status flags against the reference state.
  always @(negedge tck) begin
    if (chk_en) begin
      checkOutput("mux4", int'(mux_out4), int'(mux_in[m_sel[0]]));
      checkOutput("mux3", int'(mux_out3), int'(mux_in[m_sel[1]]));
      checkOutput("en4", int'(en4), enable_in ? (1 << m_sel[0]) : 0);
      checkOutput("en3", int'(en3), enable_in ? (1 << m_sel[1]) : 0);
      checkOutput("rerr4", int'(rerr4), int'(m_range[0]));
      checkOutput("rerr3", int'(rerr3), int'(m_range[1]));
      checkOutput("lock4", int'(lock4), int'(m_locked[0]));
      checkOutput("lock3", int'(lock3), int'(m_locked[1]));
    end
  end

  initial begin
    reset = 1'b1; sel = 1'b0; ce = 1'b0; se = 1'b0; ue = 1'b0; si = 1'b0;
    enable_in = 1'b1; mux_in = 4'b0;
    tick(); tick();
    model_reset();
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset state, idle.
    tick(); tick();
    checkOutput("rst_en4", int'(en4), 32'h1);
    checkOutput("rst_so4", int'(so4), 0);
    checkOutput("rst_mux4", int'(mux_out4), int'(mux_in[0]));

    // Good key, select 2.
    applyStimulus(8'hA5, 2, 1'b1);
    checkOutput("sel2_en4", int'(en4), 32'h4);
    checkOutput("sel2_mux4", int'(mux_out4), int'(mux_in[2]));
    capture_check("sel2");

    // Three wrong keys, then a good key.
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 3, 1'b1);
`ifdef TESSENT_SCANMUX_KEY_EN
    checkOutput("lock_after3", int'(lock4), 1);
    checkOutput("lock_sel_hold", int'(en4), 32'h4);
`else
    checkOutput("nokey_sel3", int'(en4), 32'h8);
    checkOutput("nokey_rerr3", int'(rerr3), 1);
`endif
    applyStimulus(8'hA5, 1, 1'b1);
`ifdef TESSENT_SCANMUX_KEY_EN
    checkOutput("lock_ignore", int'(en4), 32'h4);
`else
    checkOutput("nokey_sel1", int'(en4), 32'h2);
`endif
    capture_check("locked");

    reset = 1'b1; tick(); model_reset(); reset = 1'b0;
    tick();
    checkOutput("unlock_rst", int'(lock4), 0);

    // Counter clears on a good key between bad ones.
    applyStimulus(8'h00, 2, 1'b1);
    applyStimulus(8'h3C, 2, 1'b1);
    applyStimulus(8'hA5, 1, 1'b1);
    applyStimulus(8'h00, 2, 1'b1);
    applyStimulus(8'hFF, 2, 1'b1);
    checkOutput("nolock_lock4", int'(lock4), 0);
    capture_check("nolock");

    // Out-of-range select on the 3-input instance, then a legal one.
    applyStimulus(8'hA5, 3, 1'b1);
    checkOutput("range_rerr3", int'(rerr3), 1);
    checkOutput("range_rerr4", int'(rerr4), 0);
    checkOutput("range_en4", int'(en4), 32'h8);
    applyStimulus(8'hA5, 1, 1'b1);
    checkOutput("range_ok_en3", int'(en3), 32'h2);
    capture_check("range");

    // Reset together with an update of a valid word: reset wins.
    applyStimulus(8'hA5, 2, 1'b0);
    reset = 1'b1; sel = 1'b1; ue = 1'b1;
    tick();
    model_reset();
    reset = 1'b0; sel = 1'b0; ue = 1'b0;
    tick();
    checkOutput("rstupd_en4", int'(en4), 32'h1);
    checkOutput("rstupd_so4", int'(so4), 0);
    checkOutput("rstupd_rerr3", int'(rerr3), 0);

    // Enable gating off, then back on.
    enable_in = 1'b0;
    tick(); tick();
    checkOutput("en_off4", int'(en4), 0);
    enable_in = 1'b1;
    tick(); tick();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
